// File: rtl/ternary_accum_pkg.sv
// ternary_accum_pkg: network-wide width/size defaults and width helpers for the
// accumulator stage that follows the ternary select units.
package ternary_accum_pkg;

  localparam int SELECT_OUT_WIDTH = 10;
  localparam int ACCUM_LANES      = 4;
  localparam int ACCUM_TERMS      = 9;
  localparam int ACCUM_OUT_WIDTH  = 16;

  // Full-precision width of a LANES-way sum of in_width-bit signed values.
  function automatic int lane_sum_width(input int in_width, input int lanes);
    return in_width + $clog2(lanes);
  endfunction

  // Beat counter width; a single-term window still needs one bit.
  function automatic int cnt_width(input int terms);
    return (terms > 1) ? $clog2(terms) : 1;
  endfunction

endpackage

// File: rtl/ternary_accum_if.sv
// ternary_accum_if: beat input stream, window-abort and result output stream of
// the accumulator; master = upstream/consumer side, slave = accumulator.
interface ternary_accum_if
  import ternary_accum_pkg::*;
#(
  parameter int IN_WIDTH  = SELECT_OUT_WIDTH,
  parameter int LANES     = ACCUM_LANES,
  parameter int OUT_WIDTH = ACCUM_OUT_WIDTH
);
  logic                        clr;
  logic                        in_valid;
  logic                        in_ready;
  logic [LANES*IN_WIDTH-1:0]   in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        out_sat;

  modport master (
    output clr, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  clr, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/lane_adder_tree.sv
// lane_adder_tree: signed LANES-way reduction of one beat and the stage-1
// register that holds the beat sum and its valid flag.
module lane_adder_tree
  import ternary_accum_pkg::*;
#(
  parameter int IN_WIDTH  = SELECT_OUT_WIDTH,
  parameter int LANES     = ACCUM_LANES,
  parameter int SUM_WIDTH = lane_sum_width(IN_WIDTH, LANES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        clr,
  input  logic                        in_valid,
  input  logic [LANES*IN_WIDTH-1:0]   in_data,
  output logic                        s1_valid,
  output logic signed [SUM_WIDTH-1:0] s1_sum
);

  logic signed [SUM_WIDTH-1:0] lane_sum;

  // NOTE: default assignment first and blocking '=' inside always_comb: the loop
  // accumulates in order and no path leaves lane_sum unassigned, so no latch.
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + SUM_WIDTH'(signed'(in_data[i*IN_WIDTH +: IN_WIDTH]));
    end
  end

  // NOTE: registers use non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
    end else if (clr) begin
      s1_valid <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) s1_sum <= lane_sum;
    end
  end

endmodule

// File: rtl/ternary_accum.sv
// ternary_accum: sums TERMS beats of LANES signed select products into one
// window result behind a single-entry valid/ready register. ACCUM_SAT_EN
// selects clamping accumulation with a sticky per-window out_sat flag.
module ternary_accum
  import ternary_accum_pkg::*;
#(
  parameter int IN_WIDTH  = SELECT_OUT_WIDTH,
  parameter int LANES     = ACCUM_LANES,
  parameter int TERMS     = ACCUM_TERMS,
  parameter int OUT_WIDTH = ACCUM_OUT_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  ternary_accum_if.slave bus
);

  localparam int SUM_WIDTH = lane_sum_width(IN_WIDTH, LANES);
  localparam int CNT_WIDTH = cnt_width(TERMS);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TERMS - 1);

  logic                        en;
  logic                        s1_valid;
  logic signed [SUM_WIDTH-1:0] s1_sum;
  logic signed [OUT_WIDTH-1:0] acc;
  logic signed [OUT_WIDTH-1:0] acc_next;
  logic [CNT_WIDTH-1:0]        cnt;
  logic                        last;
  logic                        out_valid;
  logic signed [OUT_WIDTH-1:0] out_data;

  // A pending, unaccepted result freezes the whole pipeline (no skid buffer).
  assign en            = !out_valid || bus.out_ready;
  assign last          = (cnt == CNT_LAST);
  assign bus.in_ready  = en;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;

  lane_adder_tree #(
    .IN_WIDTH (IN_WIDTH),
    .LANES    (LANES),
    .SUM_WIDTH(SUM_WIDTH)
  ) u_tree (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .clr     (bus.clr),
    .in_valid(bus.in_valid),
    .in_data (bus.in_data),
    .s1_valid(s1_valid),
    .s1_sum  (s1_sum)
  );

`ifdef ACCUM_SAT_EN
  localparam logic signed [OUT_WIDTH-1:0] ACC_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] ACC_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic signed [OUT_WIDTH:0] acc_wide;
  logic                      clamp;
  logic                      sat_flag;
  logic                      out_sat;

  // One guard bit: the top two bits differ exactly when the sum leaves range.
  assign acc_wide = (OUT_WIDTH+1)'(acc) + (OUT_WIDTH+1)'(s1_sum);
  assign clamp    = acc_wide[OUT_WIDTH] != acc_wide[OUT_WIDTH-1];
  assign acc_next = !clamp             ? acc_wide[OUT_WIDTH-1:0] :
                    acc_wide[OUT_WIDTH] ? ACC_MIN : ACC_MAX;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag <= 1'b0;
      out_sat  <= 1'b0;
    end else if (bus.clr) begin
      sat_flag <= 1'b0;
    end else if (en && s1_valid) begin
      if (last) begin
        sat_flag <= 1'b0;
        out_sat  <= sat_flag | clamp;
      end else begin
        sat_flag <= sat_flag | clamp;
      end
    end
  end

  assign bus.out_sat = out_sat;
`else
  assign acc_next    = acc + OUT_WIDTH'(s1_sum);
  assign bus.out_sat = 1'b0;
`endif

  // The last-beat load is written after the consume-clear so a same-edge
  // handoff reloads out_data and keeps out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (bus.out_ready) out_valid <= 1'b0;
      if (bus.clr) begin
        acc <= '0;
        cnt <= '0;
      end else if (en && s1_valid) begin
        if (last) begin
          acc       <= '0;
          cnt       <= '0;
          out_valid <= 1'b1;
          out_data  <= acc_next;
        end else begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ternary_accum.sv
// tb_ternary_accum: drives a 16-bit and a 12-bit accumulator with the same
// directed and random beats and checks results against an integer window model.
module tb_ternary_accum;

  localparam int IN_W  = 10;
  localparam int LANES = 4;
  localparam int TERMS = 9;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ternary_accum_if #(.IN_WIDTH(IN_W), .LANES(LANES), .OUT_WIDTH(16)) b16 ();
  ternary_accum_if #(.IN_WIDTH(IN_W), .LANES(LANES), .OUT_WIDTH(12)) b12 ();

  ternary_accum #(.IN_WIDTH(IN_W), .LANES(LANES), .TERMS(TERMS), .OUT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b16)
  );
  ternary_accum #(.IN_WIDTH(IN_W), .LANES(LANES), .TERMS(TERMS), .OUT_WIDTH(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .bus(b12)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Window model: index 0 = 16-bit instance, index 1 = 12-bit instance.
  longint m_acc [2];
  int     m_cnt [2];
  bit     m_flag[2];
  int     q_d   [2][$];
  bit     q_s   [2][$];
  int     q_t   [$];
  int     n_out [2];
  int     last_d[2];
  bit     last_s[2];
  int     last_lat;

  task automatic check(input string tag, input int obs, input int want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  function automatic longint wrap_w(input longint x, input int w);
    longint m;
    m = x & ((64'sd1 <<< w) - 1);
    if (m >= (64'sd1 <<< (w - 1))) m = m - (64'sd1 <<< w);
    return m;
  endfunction

  task automatic model_clear_windows();
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0; m_cnt[k] = 0; m_flag[k] = 1'b0;
    end
  endtask

  task automatic model_beat(input int k, input int s);
    int     w;
    longint hi, lo;
    w  = (k == 0) ? 16 : 12;
    hi = (64'sd1 <<< (w - 1)) - 1;
    lo = -(64'sd1 <<< (w - 1));
    m_acc[k] = m_acc[k] + s;
`ifdef ACCUM_SAT_EN
    if (m_acc[k] > hi) begin m_acc[k] = hi; m_flag[k] = 1'b1; end
    else if (m_acc[k] < lo) begin m_acc[k] = lo; m_flag[k] = 1'b1; end
`endif
    m_cnt[k]++;
    if (m_cnt[k] == TERMS) begin
      q_d[k].push_back(int'(wrap_w(m_acc[k], w)));
      q_s[k].push_back(m_flag[k]);
      if (k == 0) q_t.push_back(cyc);
      m_acc[k] = 0; m_cnt[k] = 0; m_flag[k] = 1'b0;
    end
  endtask

  task automatic observe(input int k, input bit ov, input bit rdy, input int od, input bit os);
    int wd;
    bit ws;
    if (ov && rdy) begin
      n_out[k]++;
      last_d[k] = od;
      last_s[k] = os;
      check($sformatf("out_expected%0d", k), int'(q_d[k].size() > 0), 1);
      if (q_d[k].size() > 0) begin
        wd = q_d[k].pop_front();
        ws = q_s[k].pop_front();
        check($sformatf("out_data%0d", k), od, wd);
        check($sformatf("out_sat%0d", k), int'(os), int'(ws));
        if (k == 0) last_lat = cyc - q_t.pop_front();
      end
    end
  endtask

  task automatic drive(input bit v, input int l[4], input bit rdy, input bit c);
    logic [LANES*IN_W-1:0] d;
    d = '0;
    for (int i = 0; i < LANES; i++) d[i*IN_W +: IN_W] = IN_W'(l[i]);
    b16.in_valid = v; b16.in_data = d; b16.out_ready = rdy; b16.clr = c;
    b12.in_valid = v; b12.in_data = d; b12.out_ready = rdy; b12.clr = c;
  endtask

  // One clock: drive at the falling edge, account for what the next rising
  // edge will do, then return at the following falling edge.
  task automatic cycle(input bit v, input int l[4], input bit rdy, input bit c, output bit acc);
    int s;
    drive(v, l, rdy, c);
    #1;
    s = l[0] + l[1] + l[2] + l[3];
    observe(0, b16.out_valid, b16.out_ready, int'(b16.out_data), b16.out_sat);
    observe(1, b12.out_valid, b12.out_ready, int'(b12.out_data), b12.out_sat);
    acc = b16.in_valid && b16.in_ready;
    if (c) model_clear_windows();
    else begin
      if (b16.in_valid && b16.in_ready) model_beat(0, s);
      if (b12.in_valid && b12.in_ready) model_beat(1, s);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic rand_lanes(output int r[4]);
    for (int i = 0; i < 4; i++) r[i] = int'($urandom_range(0, 1023)) - 512;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  ones[4];
    int  r[4];
    bit  a;
    int  n0, got, drops;

    ones = '{1, 1, 1, 1};
    model_clear_windows();
    n_out = '{0, 0};
    last_lat = 0;

    // Reset held with random inputs.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_lanes(r);
      drive(1'($urandom_range(0, 1)), r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      #1;
      check("rst_out_valid", int'(b16.out_valid), 0);
      check("rst_out_data", int'(b16.out_data), 0);
      check("rst_out_sat", int'(b16.out_sat), 0);
      check("rst_in_ready", int'(b16.in_ready), 1);
      check("rst_out_valid12", int'(b12.out_valid), 0);
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b0, ones, 1'b1, 1'b0, a);
    check("no_spurious_after_reset", n_out[0], 0);

    // Basic sums, latency and single-cycle valid.
    n0 = n_out[0];
    for (int i = 0; i < TERMS; i++) cycle(1'b1, '{1, 2, 3, 4}, 1'b1, 1'b0, a);
    for (int i = 0; i < 5; i++) cycle(1'b0, ones, 1'b1, 1'b0, a);
    check("basic_count", n_out[0] - n0, 1);
    check("basic_sum", last_d[0], 90);
    check("basic_latency", last_lat, 2);
    for (int i = 0; i < TERMS; i++) cycle(1'b1, '{-512, -512, -512, -512}, 1'b1, 1'b0, a);
    for (int i = 0; i < 4; i++) cycle(1'b0, ones, 1'b1, 1'b0, a);
    check("neg_sum", last_d[0], -18432);

    // Saturation on the 12-bit instance, then a clean window.
    for (int i = 0; i < TERMS; i++) cycle(1'b1, '{511, 511, 511, 511}, 1'b1, 1'b0, a);
    for (int i = 0; i < 4; i++) cycle(1'b0, ones, 1'b1, 1'b0, a);
`ifdef ACCUM_SAT_EN
    check("sat12_data", last_d[1], 2047);
    check("sat12_flag", int'(last_s[1]), 1);
`else
    check("wrap12_data", last_d[1], 2012);
    check("wrap12_flag", int'(last_s[1]), 0);
`endif
    check("sat16_data", last_d[0], 18396);
    for (int i = 0; i < TERMS; i++) cycle(1'b1, ones, 1'b1, 1'b0, a);
    for (int i = 0; i < 4; i++) cycle(1'b0, ones, 1'b1, 1'b0, a);
    check("after_sat12_data", last_d[1], 36);
    check("after_sat12_flag", int'(last_s[1]), 0);

    // Backpressure: two windows back-to-back with the consumer stalled.
    n0 = n_out[0];
    got = 0;
    for (int i = 0; i < 60 && got < 2*TERMS; i++) begin
      cycle(1'b1, ones, (i >= 14), 1'b0, a);
      if (a) got++;
      if (i == 13) begin
        check("bp_in_ready_low", int'(b16.in_ready), 0);
        check("bp_out_valid_held", int'(b16.out_valid), 1);
        check("bp_out_data_held", int'(b16.out_data), 36);
      end
    end
    check("bp_beats_accepted", got, 2*TERMS);
    for (int i = 0; i < 6; i++) cycle(1'b0, ones, 1'b1, 1'b0, a);
    check("bp_count", n_out[0] - n0, 2);
    check("bp_last", last_d[0], 36);

    // Partial window aborted by clr, then a window with bubbles.
    n0 = n_out[0];
    for (int i = 0; i < 4; i++) cycle(1'b1, '{5, 5, 5, 5}, 1'b1, 1'b0, a);
    cycle(1'b0, ones, 1'b1, 1'b1, a);
    for (int i = 0; i < 2*TERMS; i++) cycle((i % 2) == 0, ones, 1'b1, 1'b0, a);
    for (int i = 0; i < 6; i++) cycle(1'b0, ones, 1'b1, 1'b0, a);
    check("clr_count", n_out[0] - n0, 1);
    check("clr_sum", last_d[0], 36);

    // Continuous random beats with the consumer always ready.
    n0 = n_out[0];
    drops = 0;
    for (int i = 0; i < 3*TERMS; i++) begin
      rand_lanes(r);
      cycle(1'b1, r, 1'b1, 1'b0, a);
      if (!a) drops++;
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, ones, 1'b1, 1'b0, a);
    check("handoff_in_ready_drops", drops, 0);
    check("handoff_count", n_out[0] - n0, 3);

    // Random valid/ready traffic.
    for (int i = 0; i < 400; i++) begin
      rand_lanes(r);
      cycle($urandom_range(0, 3) != 0, r, $urandom_range(0, 3) != 0, 1'b0, a);
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, ones, 1'b1, 1'b0, a);
    check("rand_queue16_empty", q_d[0].size(), 0);
    check("rand_queue12_empty", q_d[1].size(), 0);
    cycle(1'b0, ones, 1'b1, 1'b1, a);

    // Asynchronous reset with a pending result and a partial window.
    for (int i = 0; i < 14; i++) cycle(1'b1, ones, 1'b0, 1'b0, a);
    check("pre_reset_pending", int'(b16.out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", int'(b16.out_valid), 0);
    check("async_rst_out_data", int'(b16.out_data), 0);
    check("async_rst_in_ready", int'(b16.in_ready), 1);
    model_clear_windows();
    for (int k = 0; k < 2; k++) begin
      q_d[k].delete();
      q_s[k].delete();
    end
    q_t.delete();
    @(negedge clk);
    rst_n = 1'b1;
    n0 = n_out[0];
    for (int i = 0; i < TERMS; i++) cycle(1'b1, '{2, 2, 2, 2}, 1'b1, 1'b0, a);
    for (int i = 0; i < 4; i++) cycle(1'b0, ones, 1'b1, 1'b0, a);
    check("post_reset_count", n_out[0] - n0, 1);
    check("post_reset_sum", last_d[0], 72);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
